vga_obj_flush_master: RTL and testbench

- Avalon-MM write initiator that drives the register interface of the VGA ball peripheral.
- Game-logic producers post object, background and LFSR-mode updates into a local shadow register table; each entry carries a dirty bit.
- On each frame-sync pulse (start of vertical blank), the block flushes only dirty entries as 32-bit Avalon writes, so on-screen state changes once per frame.
- Sits between the game/control logic and the display peripheral on the same fabric clock.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_shadow_table.sv | 49 ++++
 rtl/vga_obj_flush_master.sv | 161 ++++++++++++++++
 tb/tb_vga_obj_flush_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA ball peripheral flush master.
package vga_pkg;

  localparam int unsigned MaxObjects = 20;
  localparam int unsigned NumSlots   = MaxObjects + 2;
  localparam int unsigned SlotW      = 5;
  localparam int unsigned AddrW      = 5;
  localparam int unsigned DataW      = 32;

  localparam logic [AddrW-1:0] AddrBg   = 5'd0;
  localparam logic [AddrW-1:0] AddrLfsr = 5'd21;

  // Flush order: background, lfsr, then objects 0..MaxObjects-1.
  localparam logic [SlotW-1:0] SlotBg   = 5'd0;
  localparam logic [SlotW-1:0] SlotLfsr = 5'd1;
  localparam logic [SlotW-1:0] SlotObj0 = 5'd2;
  localparam logic [SlotW-1:0] SlotLast = 5'(NumSlots - 1);

  // Object payload field positions
  localparam int unsigned XMsb      = 31;
  localparam int unsigned XLsb      = 20;
  localparam int unsigned YMsb      = 19;
  localparam int unsigned YLsb      = 8;
  localparam int unsigned SpriteMsb = 7;
  localparam int unsigned SpriteLsb = 2;
  localparam int unsigned ActiveBit = 1;

  typedef enum logic [1:0] {
    UpdObject = 2'd0,
    UpdBg     = 2'd1,
    UpdLfsr   = 2'd2,
    UpdRsvd   = 2'd3
  } upd_kind_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StWrite
  } state_e;

  function automatic logic [AddrW-1:0] slot_addr(logic [SlotW-1:0] slot);
    if (slot == SlotBg) begin
      return AddrBg;
    end else if (slot == SlotLfsr) begin
      return AddrLfsr;
    end
    return slot - 5'd1;
  endfunction

endpackage

// File: rtl/vga_shadow_table.sv
// Shadow register file with per-entry dirty bits; a set on the same entry beats a clear.
module vga_shadow_table
  import vga_pkg::*;
#(
  parameter int unsigned NumEntries = NumSlots
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [SlotW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [SlotW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o,
  output logic             rdirty_o,
  input  logic             clr_i,
  input  logic [SlotW-1:0] clr_addr_i
);

  logic [DataW-1:0]      data_q [NumEntries];
  logic [NumEntries-1:0] dirty_q, dirty_d;

  always_comb begin
    dirty_d = dirty_q;
    if (clr_i) begin
      dirty_d[clr_addr_i] = 1'b0;
    end
    if (we_i) begin
      dirty_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumEntries; i++) begin
        data_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      if (we_i) begin
        data_q[waddr_i] <= wdata_i;
      end
      dirty_q <= dirty_d;
    end
  end

  assign rdata_o  = data_q[raddr_i];
  assign rdirty_o = dirty_q[raddr_i];

endmodule

// File: rtl/vga_obj_flush_master.sv
// Avalon-MM write initiator: shadows producer updates and flushes dirty entries once per frame.
module vga_obj_flush_master
  import vga_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [1:0]       upd_kind_i,
  input  logic [4:0]       upd_idx_i,
  input  logic [DataW-1:0] upd_data_i,
  input  logic             frame_sync_i,
  output logic [AddrW-1:0] avm_address_o,
  output logic [DataW-1:0] avm_writedata_o,
  output logic             avm_write_o,
  output logic             avm_chipselect_o,
  input  logic             avm_waitrequest_i,
  output logic             busy_o,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  state_e           state_q, state_d;
  logic [SlotW-1:0] ptr_q, ptr_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             overrun_q, overrun_d;

  logic             upd_we;
  logic [SlotW-1:0] upd_slot;
  logic [DataW-1:0] rd_data;
  logic             rd_dirty;
  logic             clr_dirty;

  // Reserved kinds and out-of-range object indices are accepted but dropped.
  always_comb begin
    upd_we   = 1'b0;
    upd_slot = '0;
    if (upd_valid_i) begin
      unique case (upd_kind_e'(upd_kind_i))
        UpdObject: begin
          if (upd_idx_i < 5'(MaxObjects)) begin
            upd_we   = 1'b1;
            upd_slot = upd_idx_i + SlotObj0;
          end
        end
        UpdBg: begin
          upd_we   = 1'b1;
          upd_slot = SlotBg;
        end
        UpdLfsr: begin
          upd_we   = 1'b1;
          upd_slot = SlotLfsr;
        end
        UpdRsvd: begin
          upd_we = 1'b0;
        end
        default: begin
          upd_we = 1'b0;
        end
      endcase
    end
  end

  vga_shadow_table #(
    .NumEntries(NumSlots)
  ) u_shadow (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (upd_we),
    .waddr_i    (upd_slot),
    .wdata_i    (upd_data_i),
    .raddr_i    (ptr_q),
    .rdata_o    (rd_data),
    .rdirty_o   (rd_dirty),
    .clr_i      (clr_dirty),
    .clr_addr_i (ptr_q)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    clr_dirty = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_sync_i) begin
          state_d = StScan;
          ptr_d   = '0;
        end
      end
      StScan: begin
        if (rd_dirty) begin
          state_d = StWrite;
          addr_d  = slot_addr(ptr_q);
          wdata_d = rd_data;
          write_d = 1'b1;
        end else if (ptr_q == SlotLast) begin
          state_d = StIdle;
        end else begin
          ptr_d = ptr_q + 5'd1;
        end
      end
      StWrite: begin
        if (!avm_waitrequest_i) begin
          clr_dirty = 1'b1;
          write_d   = 1'b0;
          if (ptr_q == SlotLast) begin
            state_d = StIdle;
          end else begin
            state_d = StScan;
            ptr_d   = ptr_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A frame_sync that cannot start a flush is flagged; the set beats a same-cycle clear.
  always_comb begin
    overrun_d = overrun_q;
    if (frame_sync_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
    end
  end

  assign upd_ready_o      = 1'b1;
  assign avm_address_o    = addr_q;
  assign avm_writedata_o  = wdata_q;
  assign avm_write_o      = write_q;
  assign avm_chipselect_o = write_q;
  assign busy_o           = (state_q != StIdle);
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_vga_obj_flush_master.sv
// Bench for vga_obj_flush_master: directed scenarios plus random traffic against a flush-plan model.
module tb_vga_obj_flush_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [1:0]  upd_kind = '0;
  logic [4:0]  upd_idx = '0;
  logic [31:0] upd_data = '0;
  logic        frame_sync = 1'b0;
  logic [4:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  always #5 clk = ~clk;

  vga_obj_flush_master dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .upd_valid_i       (upd_valid),
    .upd_ready_o       (upd_ready),
    .upd_kind_i        (upd_kind),
    .upd_idx_i         (upd_idx),
    .upd_data_i        (upd_data),
    .frame_sync_i      (frame_sync),
    .avm_address_o     (avm_address),
    .avm_writedata_o   (avm_writedata),
    .avm_write_o       (avm_write),
    .avm_chipselect_o  (avm_chipselect),
    .avm_waitrequest_i (avm_waitrequest),
    .busy_o            (busy),
    .overrun_o         (overrun),
    .overrun_clr_i     (overrun_clr)
  );

  // Model: shadow contents plus a flush plan built at frame_sync, one item per bus cycle.
  typedef struct {
    bit          is_wr;
    int          slot;
    logic [4:0]  addr;
    logic [31:0] data;
  } item_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } xfer_t;

  item_t       plan[$];
  xfer_t       log_q[$];
  logic [31:0] m_val[22];
  bit          m_dirty[22];
  bit          m_overrun;
  int          n_pass = 0;
  int          n_total = 0;
  int          busy_cnt = 0;
  int          wr_cycles = 0;

  function automatic logic [4:0] exp_addr(int slot);
    if (slot == 0) return 5'd0;
    if (slot == 1) return 5'd21;
    return 5'(slot - 1);
  endfunction

  function automatic int upd_slot_of(logic [1:0] k, logic [4:0] idx);
    if (k == 2'd0) return (idx < 5'd20) ? int'(idx) + 2 : -1;
    if (k == 2'd1) return 0;
    if (k == 2'd2) return 1;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan.delete();
      for (int i = 0; i < 22; i++) begin
        m_val[i]   = '0;
        m_dirty[i] = 1'b0;
      end
      m_overrun = 1'b0;
    end else begin
      bit was_busy;
      int s;
      was_busy = (plan.size() > 0);
      if (was_busy) begin
        if (!plan[0].is_wr) begin
          void'(plan.pop_front());
        end else if (!avm_waitrequest) begin
          m_dirty[plan[0].slot] = 1'b0;
          void'(plan.pop_front());
        end
      end
      if (upd_valid) begin
        s = upd_slot_of(upd_kind, upd_idx);
        if (s >= 0) begin
          m_val[s]   = upd_data;
          m_dirty[s] = 1'b1;
        end
      end
      if (frame_sync && was_busy) m_overrun = 1'b1;
      else if (overrun_clr) m_overrun = 1'b0;
      if (frame_sync && !was_busy) begin
        for (int i = 0; i < 22; i++) begin
          plan.push_back('{is_wr: 1'b0, slot: i, addr: exp_addr(i), data: m_val[i]});
          if (m_dirty[i]) plan.push_back('{is_wr: 1'b1, slot: i, addr: exp_addr(i), data: m_val[i]});
        end
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      bit ew;
      ew = (plan.size() > 0) && plan[0].is_wr;
      chk("avm_write", 32'(avm_write), 32'(ew));
      chk("avm_chipselect", 32'(avm_chipselect), 32'(ew));
      if (ew) begin
        chk("avm_address", 32'(avm_address), 32'(plan[0].addr));
        chk("avm_writedata", avm_writedata, plan[0].data);
      end
      chk("busy", 32'(busy), 32'(plan.size() > 0));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("upd_ready", 32'(upd_ready), 32'd1);
      if (busy) busy_cnt++;
      if (avm_write) wr_cycles++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && avm_write && !avm_waitrequest) log_q.push_back('{a: avm_address, d: avm_writedata});
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    upd_valid   = 1'b0;
    frame_sync  = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic upd(logic [1:0] k, logic [4:0] i, logic [31:0] d);
    upd_valid = 1'b1;
    upd_kind  = k;
    upd_idx   = i;
    upd_data  = d;
    step();
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (plan.size() > 0 && n < 400) begin
      step();
      n++;
    end
    chk("flush_within_bound", 32'(plan.size()), 32'd0);
  endtask

  task automatic clear_log();
    log_q.delete();
    busy_cnt  = 0;
    wr_cycles = 0;
  endtask

  task automatic chk_log(int k, logic [4:0] a, logic [31:0] d);
    if (k < log_q.size()) begin
      chk($sformatf("log%0d_addr", k), 32'(log_q[k].a), 32'(a));
      chk($sformatf("log%0d_data", k), log_q[k].d, d);
    end else begin
      chk($sformatf("log%0d_present", k), 32'(log_q.size()), 32'(k + 1));
    end
  endtask

  initial begin
    int n;
    int st;
    bit done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_avm_addr", 32'(avm_address), 32'd0);
    chk("rst_avm_data", avm_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Empty flush: 22 scan cycles, no writes
    clear_log();
    fsync();
    wait_idle();
    chk("empty_busy_cycles", 32'(busy_cnt), 32'd22);
    chk("empty_writes", 32'(log_q.size()), 32'd0);
    chk("empty_overrun", 32'(overrun), 32'd0);

    // Single object write, then dirty is gone
    upd(2'd0, 5'd3, 32'h0C80F006);
    clear_log();
    fsync();
    wait_idle();
    chk("obj3_writes", 32'(log_q.size()), 32'd1);
    chk_log(0, 5'd4, 32'h0C80F006);
    chk("obj3_busy_cycles", 32'(busy_cnt), 32'd23);
    clear_log();
    fsync();
    wait_idle();
    chk("obj3_rewrite", 32'(log_q.size()), 32'd0);

    // Flush order: bg, lfsr, object 0
    upd(2'd1, 5'd0, 32'h00102030);
    upd(2'd2, 5'd0, 32'h00000001);
    upd(2'd0, 5'd0, 32'h12345678);
    upd(2'd3, 5'd9, 32'hFFFFFFFF);
    upd(2'd0, 5'd25, 32'hFFFFFFFF);
    clear_log();
    fsync();
    wait_idle();
    chk("order_writes", 32'(log_q.size()), 32'd3);
    chk_log(0, 5'd0, 32'h00102030);
    chk_log(1, 5'd21, 32'h00000001);
    chk_log(2, 5'd1, 32'h12345678);

    // Five stall cycles on one write
    upd(2'd1, 5'd0, 32'h00ABCDEF);
    clear_log();
    avm_waitrequest = 1'b1;
    fsync();
    n  = 0;
    st = 0;
    while (plan.size() > 0 && n < 100) begin
      if (plan[0].is_wr) begin
        if (st < 5) begin
          avm_waitrequest = 1'b1;
          st++;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
      step();
      n++;
    end
    avm_waitrequest = 1'b0;
    chk("stall_write_cycles", 32'(wr_cycles), 32'd6);
    chk("stall_writes", 32'(log_q.size()), 32'd1);
    chk_log(0, 5'd0, 32'h00ABCDEF);

    // Update lands in the completion cycle of the same slot
    upd(2'd0, 5'd3, 32'h0C80F006);
    clear_log();
    fsync();
    n    = 0;
    done = 1'b0;
    while (plan.size() > 0 && n < 100) begin
      if (!done && plan[0].is_wr && plan[0].slot == 5) begin
        upd_valid = 1'b1;
        upd_kind  = 2'd0;
        upd_idx   = 5'd3;
        upd_data  = 32'h0C90F006;
        done      = 1'b1;
      end
      step();
      n++;
    end
    chk("sim_first_writes", 32'(log_q.size()), 32'd1);
    chk_log(0, 5'd4, 32'h0C80F006);
    clear_log();
    fsync();
    wait_idle();
    chk("sim_second_writes", 32'(log_q.size()), 32'd1);
    chk_log(0, 5'd4, 32'h0C90F006);

    // frame_sync during a flush
    upd(2'd1, 5'd0, 32'h00445566);
    upd(2'd0, 5'd10, 32'hA0B0C0D0);
    clear_log();
    fsync();
    step();
    fsync();
    chk("overrun_set", 32'(overrun), 32'd1);
    frame_sync  = 1'b1;
    overrun_clr = 1'b1;
    step();
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    wait_idle();
    chk("overrun_flush_writes", 32'(log_q.size()), 32'd2);
    chk_log(0, 5'd0, 32'h00445566);
    chk_log(1, 5'd11, 32'hA0B0C0D0);
    overrun_clr = 1'b1;
    step();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // frame_sync on the last scan cycle still counts as busy
    fsync();
    repeat (21) step();
    fsync();
    chk("overrun_last_scan", 32'(overrun), 32'd1);
    wait_idle();
    overrun_clr = 1'b1;
    step();

    // Reset in the middle of a stalled write
    upd(2'd1, 5'd0, 32'h00010203);
    upd(2'd0, 5'd7, 32'h55AA55AA);
    avm_waitrequest = 1'b1;
    fsync();
    n = 0;
    while (!(plan.size() > 0 && plan[0].is_wr) && n < 50) begin
      step();
      n++;
    end
    chk("pre_reset_write", 32'(avm_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write", 32'(avm_write), 32'd0);
    chk("reset_drops_cs", 32'(avm_chipselect), 32'd0);
    chk("reset_drops_busy", 32'(busy), 32'd0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    clear_log();
    fsync();
    wait_idle();
    chk("post_reset_writes", 32'(log_q.size()), 32'd0);
    chk("post_reset_busy_cycles", 32'(busy_cnt), 32'd22);

    // Random traffic; updates only target slots the scan has already reached
    for (int c = 0; c < 4000; c++) begin
      logic [1:0] k;
      logic [4:0] ix;
      int s;
      avm_waitrequest = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        k  = 2'($urandom_range(0, 3));
        ix = 5'($urandom_range(0, 31));
        s  = upd_slot_of(k, ix);
        if (!(plan.size() > 0 && s > plan[0].slot)) begin
          upd_valid = 1'b1;
          upd_kind  = k;
          upd_idx   = ix;
          upd_data  = $urandom;
        end
      end
      frame_sync  = ($urandom_range(0, 39) == 0);
      overrun_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    avm_waitrequest = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
